// File: rtl/message_scheduler.sv
// Fetches one 512-bit block as 16 words, then streams SHA-256 schedule W0..W63 (W0 valid 1 cycle after last capture).
// Backpressure: while w_ready is low, w_out/round/w_valid hold and the buffer is not written.
module message_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        req_word,
  output logic [3:0]  word_address,
  output logic [31:0] w_out,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [5:0]  round,
  output logic        busy,
  output logic        block_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [1:0]  state;
  logic [31:0] msg_buf [16];
  logic [3:0]  rd;
  logic [31:0] sched;
  logic [31:0] next_w;
  logic        xfer;
  logic        capture;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // With round = t, the buffer holds W[t-15..t]; these taps give W[t+1] from
  // W[t-1], W[t-6], W[t-14] and W[t-15] (the slot about to be overwritten).
  always_comb begin
    rd     = round[3:0];
    sched  = sig1(msg_buf[rd - 4'd1]) + msg_buf[rd - 4'd6]
           + sig0(msg_buf[rd + 4'd2]) + msg_buf[rd + 4'd1];
    next_w = (round < 6'd15) ? msg_buf[rd + 4'd1] : sched;
  end

  assign capture = (state == FETCH) && word_valid && !abort;
  assign xfer    = (state == STREAM) && w_valid && w_ready && !abort;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (capture) begin
      msg_buf[word_address] <= word_data;
    end else if (xfer && (round >= 6'd15) && (round != 6'd63)) begin
      msg_buf[rd + 4'd1] <= sched;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_word     <= 1'b0;
      word_address <= 4'd0;
      w_out        <= 32'd0;
      w_valid      <= 1'b0;
      round        <= 6'd0;
      block_done   <= 1'b0;
    end else begin
      block_done <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        req_word     <= 1'b0;
        word_address <= 4'd0;
        w_out        <= 32'd0;
        w_valid      <= 1'b0;
        round        <= 6'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= FETCH;
              req_word     <= 1'b1;
              word_address <= 4'd0;
            end
          end
          FETCH: begin
            if (word_valid) begin
              if (word_address == 4'd15) begin
                // Word 0 is already buffered, so W0 can be presented right away.
                state        <= STREAM;
                req_word     <= 1'b0;
                word_address <= 4'd0;
                w_out        <= msg_buf[0];
                round        <= 6'd0;
                w_valid      <= 1'b1;
              end else begin
                word_address <= word_address + 4'd1;
              end
            end
          end
          STREAM: begin
            if (w_ready) begin
              if (round == 6'd63) begin
                state      <= IDLE;
                w_valid    <= 1'b0;
                round      <= 6'd0;
                block_done <= 1'b1;
              end else begin
                w_out <= next_w;
                round <= round + 6'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_message_scheduler.sv
// Randomised bench for message_scheduler against a plain-array SHA-256 schedule model.
module tb_message_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] word_data;
  logic        word_valid;
  logic        req_word;
  logic [3:0]  word_address;
  logic [31:0] w_out;
  logic        w_valid;
  logic        w_ready;
  logic [5:0]  round;
  logic        busy;
  logic        block_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] blk [16];
  logic [31:0] wexp [64];
  logic [31:0] got [64];

  message_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid),
    .req_word(req_word), .word_address(word_address),
    .w_out(w_out), .w_valid(w_valid), .w_ready(w_ready),
    .round(round), .busy(busy), .block_done(block_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic make_block(input bit use_abc);
    for (int i = 0; i < 16; i++) blk[i] = use_abc ? 32'd0 : $urandom;
    if (use_abc) begin
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
    end
    for (int j = 0; j < 64; j++) begin
      if (j < 16) wexp[j] = blk[j];
      else wexp[j] = s1(wexp[j-2]) + wexp[j-7] + s0(wexp[j-15]) + wexp[j-16];
      got[j] = 32'hxxxxxxxx;
    end
  endtask

  // Runs one block from a negedge; returns at the negedge where block_done is seen,
  // or after an abort / reset has been injected and checked.
  task automatic run_stream(input bit gap, input bit stall, input int abort_word,
                            input int abort_rnd, input int rst_rnd, input bit poke_start,
                            output int lat, output bit done_seen);
    int  exp_idx;
    int  cap;
    bit  fin;
    bit  abort_now;
    logic [45:0] outs;
    exp_idx = 0; cap = 0; lat = 0; done_seen = 0; fin = 0;
    start = 1'b1; abort = 1'b0; word_valid = 1'b0; w_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; abort = 1'b0; abort_now = 0;
      if (block_done) begin
        n_checks++;
        if (exp_idx !== 64) $display("FAIL done_timing: transfers %0d required 64", exp_idx);
        else n_pass++;
        lat = cyc; done_seen = 1; fin = 1;
      end else if (req_word) begin
        n_checks++;
        if (word_address !== cap[3:0]) $display("FAIL fetch_addr: got %0d required %0d", word_address, cap);
        else n_pass++;
        word_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        word_data  = word_valid ? blk[word_address] : $urandom;
        if (poke_start && cap == 5) start = 1'b1;
        if (abort_word >= 0 && cap == abort_word) begin
          abort = 1'b1; word_valid = 1'b1; abort_now = 1;
        end else if (word_valid) cap++;
      end else begin
        word_valid = 1'($urandom_range(0, 1));
        word_data  = $urandom;
        if (w_valid) begin
          n_checks++;
          if (exp_idx > 63 || round !== exp_idx[5:0])
            $display("FAIL round: got %0d required %0d", round, exp_idx);
          else n_pass++;
          if (exp_idx <= 63) begin
            n_checks++;
            if (w_out !== wexp[exp_idx])
              $display("FAIL w_out[%0d]: got %h required %h", exp_idx, w_out, wexp[exp_idx]);
            else n_pass++;
            got[exp_idx] = w_out;
          end
          w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          if (poke_start && exp_idx == 30) start = 1'b1;
          if (abort_rnd >= 0 && exp_idx == abort_rnd) begin
            abort = 1'b1; w_ready = 1'b1; abort_now = 1;
          end else if (rst_rnd >= 0 && exp_idx == rst_rnd) begin
            rst_n = 1'b0;
            #1;
            outs = {req_word, word_address, w_out, w_valid, round, busy, block_done};
            n_checks++;
            if (outs !== 46'd0) $display("FAIL reset_mid: outputs %h required 0", outs);
            else n_pass++;
            @(negedge clk);
            rst_n = 1'b1;
            fin = 1;
          end else if (w_ready) exp_idx++;
        end
      end
      if (abort_now) begin
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; word_valid = 1'b0;
        outs = {req_word, word_address, w_out, w_valid, round, busy, block_done};
        n_checks++;
        if (outs !== 46'd0) $display("FAIL abort_outputs: outputs %h required 0", outs);
        else n_pass++;
        outs = 46'd0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (block_done || busy) outs = 46'd1;
        end
        n_checks++;
        if (outs !== 46'd0) $display("FAIL abort_quiet: done/busy seen %0d required 0", outs[0]);
        else n_pass++;
        fin = 1;
      end
    end
    if (!fin) begin
      n_checks++;
      $display("FAIL timeout: block did not finish, transfers %0d required 64", exp_idx);
    end
  endtask

  task automatic check_done(input string name, input bit done_seen);
    n_checks++;
    if (done_seen !== 1'b1) $display("FAIL %s: block_done %0d required 1", name, done_seen);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [45:0] outs;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    word_data = 32'd0; w_ready = 1'b1;
    repeat (3) @(negedge clk);
    outs = {req_word, word_address, w_out, w_valid, round, busy, block_done};
    n_checks++;
    if (outs !== 46'd0) $display("FAIL reset_state: outputs %h required 0", outs);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc;
    int lat; bit done;
    make_block(1'b1);
    run_stream(1'b0, 1'b0, -1, -1, -1, 1'b0, lat, done);
    check_done("abc_done", done);
    n_checks++;
    if (lat !== 81) $display("FAIL abc_latency: got %0d required 81", lat);
    else n_pass++;
    n_checks++;
    if (got[16] !== 32'h61626380) $display("FAIL abc_w16: got %h required 61626380", got[16]);
    else n_pass++;
    n_checks++;
    if (got[17] !== 32'h000F0000) $display("FAIL abc_w17: got %h required 000f0000", got[17]);
    else n_pass++;
    n_checks++;
    if (got[18] !== 32'h7DA86405) $display("FAIL abc_w18: got %h required 7da86405", got[18]);
    else n_pass++;
    n_checks++;
    if (got[19] !== 32'h600003C6) $display("FAIL abc_w19: got %h required 600003c6", got[19]);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_gapped_fetch;
    int lat; bit done;
    make_block(1'b1);
    run_stream(1'b1, 1'b0, -1, -1, -1, 1'b0, lat, done);
    check_done("gapped_done", done);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall;
    int lat; bit done;
    make_block(1'b0);
    run_stream(1'b0, 1'b1, -1, -1, -1, 1'b0, lat, done);
    check_done("stall_done", done);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat; bit done;
    make_block(1'b0);
    run_stream(1'b1, 1'b1, -1, -1, -1, 1'b1, lat, done);
    check_done("poke_done", done);
    make_block(1'b0);
    run_stream(1'b0, 1'b0, -1, -1, -1, 1'b0, lat, done);
    check_done("b2b_done", done);
    n_checks++;
    if (lat !== 81) $display("FAIL b2b_latency: got %0d required 81", lat);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort;
    int lat; bit done;
    make_block(1'b0);
    run_stream(1'b1, 1'b0, 7, -1, -1, 1'b0, lat, done);
    make_block(1'b1);
    run_stream(1'b0, 1'b0, -1, -1, -1, 1'b0, lat, done);
    check_done("after_abort_fetch", done);
    make_block(1'b0);
    run_stream(1'b0, 1'b1, -1, 40, -1, 1'b0, lat, done);
    make_block(1'b0);
    run_stream(1'b1, 1'b1, -1, -1, -1, 1'b0, lat, done);
    check_done("after_abort_stream", done);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat; bit done;
    make_block(1'b0);
    run_stream(1'b0, 1'b0, -1, -1, 20, 1'b0, lat, done);
    make_block(1'b0);
    run_stream(1'b1, 1'b1, -1, -1, -1, 1'b0, lat, done);
    check_done("after_reset", done);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_gapped_fetch();
    test_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
